// File: rtl/sipo16.sv
// -----------------------------------------------------------------------------
// sipo16 -- 16-bit serial-in / parallel-out receiver with one-word output buffer
//
// Serial bits arrive LSB first: the bit accepted at slot k lands in collect
// register bit k.  When a frame completes, the word is handed to the output
// register on that same edge if the output is free.  Otherwise the word is
// dropped and the sticky overrun flag is set.  While a word waits at the
// output, collection of the next frame carries on, which gives one frame of
// buffering.
//
// Optional feature (macro PARITY_EN):
//   Frames are 17 bits long: 16 data bits followed by one even-parity bit.
//   A frame whose 17 bits do not XOR to zero is dropped, and parity_err
//   pulses for one cycle.  Slot reads 15 while the parity bit is awaited.
//   Without the macro, frames are 16 bits and parity_err is held at 0.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   synchronous active-low reset
//   din          in   serial data bit
//   din_valid    in   din qualifier
//   sync         in   frame realign: slot -> 0, partial frame discarded
//   dout_ready   in   consumer accepts dout
//   overrun_clr  in   clears the overrun flag
//   dout         out  [15:0] assembled word
//   dout_valid   out  dout holds an unconsumed word
//   slot         out  [3:0] index of the next bit to be captured
//   overrun      out  sticky: a completed word was dropped
//   parity_err   out  one-cycle pulse on parity failure (PARITY_EN only)
// -----------------------------------------------------------------------------
module sipo16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din,
    input  logic        din_valid,
    input  logic        sync,
    input  logic        dout_ready,
    input  logic        overrun_clr,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic [3:0]  slot,
    output logic        overrun,
    output logic        parity_err
);

`ifdef PARITY_EN
    // Even parity over 16 data bits plus the parity bit.
    function automatic logic even_parity_ok(input logic [15:0] data, input logic pbit);
        return ~((^data) ^ pbit);
    endfunction

    logic        par_wait_q;
    logic        par_wait_d;
`endif

    logic [15:0] collect_q;
    logic [15:0] collect_d;
    logic [3:0]  slot_q;
    logic [3:0]  slot_d;
    logic [15:0] dout_q;
    logic [15:0] dout_d;
    logic        dout_valid_q;
    logic        dout_valid_d;
    logic        overrun_q;
    logic        overrun_d;
    logic        parity_err_q;
    logic        parity_err_d;

    logic        frame_ok_s;
    logic [15:0] word_s;
    logic        output_free_s;
    logic        overrun_event_s;

    // Collection: slot counter, collect register and frame-completion detect.
    always_comb begin
        collect_d    = collect_q;
        slot_d       = slot_q;
        frame_ok_s   = 1'b0;
        word_s       = collect_q;
        parity_err_d = 1'b0;
`ifdef PARITY_EN
        par_wait_d   = par_wait_q;
`endif
        if (sync) begin
            // Realign: never completes a frame; a coincident bit becomes slot 0.
            collect_d = 16'h0000;
`ifdef PARITY_EN
            par_wait_d = 1'b0;
`endif
            if (din_valid) begin
                collect_d[0] = din;
                slot_d       = 4'd1;
            end else begin
                slot_d       = 4'd0;
            end
        end else if (din_valid) begin
`ifdef PARITY_EN
            if (par_wait_q) begin
                frame_ok_s   = even_parity_ok(collect_q, din);
                parity_err_d = ~frame_ok_s;
                word_s       = collect_q;
                par_wait_d   = 1'b0;
                slot_d       = 4'd0;
            end else begin
                collect_d[slot_q] = din;
                if (slot_q == 4'd15) begin
                    // Slot stays at 15 while the parity bit is outstanding.
                    par_wait_d = 1'b1;
                end else begin
                    slot_d = slot_q + 4'd1;
                end
            end
`else
            collect_d[slot_q] = din;
            if (slot_q == 4'd15) begin
                frame_ok_s = 1'b1;
                word_s     = {din, collect_q[14:0]};
                slot_d     = 4'd0;
            end else begin
                slot_d     = slot_q + 4'd1;
            end
`endif
        end else begin
            slot_d = slot_q;
        end
    end

    // Output handshake: load, hold, drain, and overrun detection.
    always_comb begin
        dout_d          = dout_q;
        dout_valid_d    = dout_valid_q;
        overrun_event_s = 1'b0;
        output_free_s   = (~dout_valid_q) | dout_ready;
        if (frame_ok_s) begin
            if (output_free_s) begin
                dout_d       = word_s;
                dout_valid_d = 1'b1;
            end else begin
                overrun_event_s = 1'b1;
            end
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end else begin
            dout_valid_d = dout_valid_q;
        end
        // A new overrun wins over a coincident clear.
        overrun_d = (overrun_q & ~overrun_clr) | overrun_event_s;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collect_q    <= 16'h0000;
            slot_q       <= 4'd0;
            dout_q       <= 16'h0000;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef PARITY_EN
            par_wait_q   <= 1'b0;
`endif
        end else begin
            collect_q    <= collect_d;
            slot_q       <= slot_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
`ifdef PARITY_EN
            par_wait_q   <= par_wait_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign slot       = slot_q;
    assign overrun    = overrun_q;
    assign parity_err = parity_err_q;

endmodule
